// File: rtl/lcd_pkg.sv
// Shared DCS opcodes and command-FSM encoding for the LCD SPI link.
// The panel driver's init table uses the same opcode constants.
package lcd_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] DCS_SLPIN   = 8'h10;
    localparam logic [BYTE_W-1:0] DCS_SLPOUT  = 8'h11;
    localparam logic [BYTE_W-1:0] DCS_DISPOFF = 8'h28;
    localparam logic [BYTE_W-1:0] DCS_DISPON  = 8'h29;
    localparam logic [BYTE_W-1:0] DCS_CASET   = 8'h2A;
    localparam logic [BYTE_W-1:0] DCS_RASET   = 8'h2B;
    localparam logic [BYTE_W-1:0] DCS_RAMWR   = 8'h2C;
    localparam logic [BYTE_W-1:0] DCS_MADCTL  = 8'h36;
    localparam logic [BYTE_W-1:0] DCS_COLMOD  = 8'h3A;

    typedef enum logic [2:0] {
        S_CMD,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_PARAM1,
        S_SKIP
    } state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronisers, SCLK rise detect, MSB-first shifter.
// Also synchronises the panel reset so the top level can use it as a synchronous clear.
module spi_byte_rx
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lcd_resetn,
    input  logic              lcd_clk,
    input  logic              lcd_cs,
    input  logic              lcd_rs,
    input  logic              lcd_data,
    output logic              panel_rstn,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_dc,
    output logic              rx_strobe,
    output logic              rx_abort
);

    logic [SYNC_STAGES-1:0] rst_sync, clk_sync, cs_sync, rs_sync, dat_sync;
    logic                   clk_q;
    logic [BYTE_W-2:0]      shreg;
    logic [2:0]             bit_cnt;
    logic                   dc_q;
    logic                   sclk_rise;

    // Synchroniser chains; CS idles deasserted, panel reset starts asserted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= '0;
            clk_sync <= '0;
            cs_sync  <= '1;
            rs_sync  <= '0;
            dat_sync <= '0;
            clk_q    <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], lcd_resetn};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], lcd_clk};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], lcd_cs};
            rs_sync  <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], lcd_data};
            clk_q    <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign panel_rstn = rst_sync[SYNC_STAGES-1];
    assign sclk_rise  = clk_sync[SYNC_STAGES-1] & ~clk_q;

    // Bit assembly; CS high drops any partial byte and flags it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            dc_q      <= 1'b0;
            rx_byte   <= '0;
            rx_dc     <= 1'b0;
            rx_strobe <= 1'b0;
            rx_abort  <= 1'b0;
        end else if (!panel_rstn) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            dc_q      <= 1'b0;
            rx_byte   <= '0;
            rx_dc     <= 1'b0;
            rx_strobe <= 1'b0;
            rx_abort  <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            rx_abort  <= 1'b0;
            if (cs_sync[SYNC_STAGES-1]) begin
                if (bit_cnt != 3'd0) rx_abort <= 1'b1;
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[BYTE_W-3:0], dat_sync[SYNC_STAGES-1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd0) dc_q <= rs_sync[SYNC_STAGES-1];
                if (bit_cnt == 3'd7) begin
                    rx_byte   <= {shreg, dat_sync[SYNC_STAGES-1]};
                    rx_dc     <= dc_q;
                    rx_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_sink.sv
// Panel-side model of the 4-wire LCD SPI link: decodes the DCS stream into
// addressed RGB565 pixel writes and panel status flags.
module lcd_spi_sink
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COORD_W     = 9
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               lcd_resetn,
    input  logic               lcd_clk,
    input  logic               lcd_cs,
    input  logic               lcd_rs,
    input  logic               lcd_data,
    output logic               cmd_valid,
    output logic [BYTE_W-1:0]  cmd_code,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_data,
    output logic               sleep_out,
    output logic               disp_on,
    output logic [BYTE_W-1:0]  madctl,
    output logic [BYTE_W-1:0]  colmod,
    output logic               err_abort
);

    logic              panel_rstn;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_dc, rx_strobe;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .lcd_resetn (lcd_resetn),
        .lcd_clk    (lcd_clk),
        .lcd_cs     (lcd_cs),
        .lcd_rs     (lcd_rs),
        .lcd_data   (lcd_data),
        .panel_rstn (panel_rstn),
        .rx_byte    (rx_byte),
        .rx_dc      (rx_dc),
        .rx_strobe  (rx_strobe),
        .rx_abort   (err_abort)
    );

    state_t             state;
    logic [1:0]         par_cnt;
    logic [BYTE_W-1:0]  par0, par1, par2, hi_byte;
    logic               par_sel, lo_phase;
    logic [COORD_W-1:0] xs, xe, ys, ye, x, y;
    logic [COORD_W-1:0] win_start, win_end;

    // Window bounds are 16-bit big-endian on the wire, truncated to the counter width
    assign win_start = COORD_W'({par0, par1});
    assign win_end   = COORD_W'({par2, rx_byte});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_CMD;    par_cnt <= '0;     par_sel <= 1'b0;  lo_phase <= 1'b0;
            par0 <= '0;        par1 <= '0;        par2 <= '0;       hi_byte <= '0;
            xs <= '0;          ys <= '0;          xe <= '1;         ye <= '1;
            x <= '0;           y <= '0;
            cmd_valid <= 1'b0; cmd_code <= '0;    pix_valid <= 1'b0;
            pix_x <= '0;       pix_y <= '0;       pix_data <= '0;
            sleep_out <= 1'b0; disp_on <= 1'b0;   madctl <= '0;     colmod <= '0;
        end else if (!panel_rstn) begin
            state <= S_CMD;    par_cnt <= '0;     par_sel <= 1'b0;  lo_phase <= 1'b0;
            par0 <= '0;        par1 <= '0;        par2 <= '0;       hi_byte <= '0;
            xs <= '0;          ys <= '0;          xe <= '1;         ye <= '1;
            x <= '0;           y <= '0;
            cmd_valid <= 1'b0; cmd_code <= '0;    pix_valid <= 1'b0;
            pix_x <= '0;       pix_y <= '0;       pix_data <= '0;
            sleep_out <= 1'b0; disp_on <= 1'b0;   madctl <= '0;     colmod <= '0;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            if (rx_strobe && !rx_dc) begin
                // Every command byte ends whatever command was in progress
                cmd_valid <= 1'b1;
                cmd_code  <= rx_byte;
                par_cnt   <= '0;
                case (rx_byte)
                    DCS_CASET:   state <= S_CASET;
                    DCS_RASET:   state <= S_RASET;
                    DCS_RAMWR: begin
                        state    <= S_RAMWR;
                        x        <= xs;
                        y        <= ys;
                        lo_phase <= 1'b0;
                    end
                    DCS_MADCTL:  begin state <= S_PARAM1; par_sel <= 1'b0; end
                    DCS_COLMOD:  begin state <= S_PARAM1; par_sel <= 1'b1; end
                    DCS_SLPOUT:  begin state <= S_CMD; sleep_out <= 1'b1; end
                    DCS_SLPIN:   begin state <= S_CMD; sleep_out <= 1'b0; end
                    DCS_DISPON:  begin state <= S_CMD; disp_on <= 1'b1; end
                    DCS_DISPOFF: begin state <= S_CMD; disp_on <= 1'b0; end
                    default:     state <= S_SKIP;
                endcase
            end else if (rx_strobe) begin
                case (state)
                    S_CASET, S_RASET: begin
                        par_cnt <= par_cnt + 2'd1;
                        case (par_cnt)
                            2'd0: par0 <= rx_byte;
                            2'd1: par1 <= rx_byte;
                            2'd2: par2 <= rx_byte;
                            default: begin
                                if (state == S_CASET) begin
                                    xs <= win_start;
                                    xe <= win_end;
                                end else begin
                                    ys <= win_start;
                                    ye <= win_end;
                                end
                                state <= S_CMD;
                            end
                        endcase
                    end
                    S_PARAM1: begin
                        if (par_sel) colmod <= rx_byte;
                        else         madctl <= rx_byte;
                        state <= S_SKIP;
                    end
                    S_RAMWR: begin
                        lo_phase <= ~lo_phase;
                        if (!lo_phase) begin
                            hi_byte <= rx_byte;
                        end else begin
                            pix_valid <= 1'b1;
                            pix_data  <= {hi_byte, rx_byte};
                            pix_x     <= x;
                            pix_y     <= y;
                            // Raster advance inside the window; wraps indefinitely
                            if (x == xe) begin
                                x <= xs;
                                y <= (y == ye) ? ys : y + COORD_W'(1);
                            end else begin
                                x <= x + COORD_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Self-checking bench for lcd_spi_sink: flag/command vector table, directed
// window/abort/reset sequences, and a randomized DCS stream against a reference model.
module tb_lcd_spi_sink;

    localparam int unsigned CW   = 9;
    localparam int          SPAN = 1 << CW;

    logic clk = 1'b0, resetn = 1'b0, lcd_resetn = 1'b1;
    logic lcd_clk = 1'b0, lcd_cs = 1'b1, lcd_rs = 1'b0, lcd_data = 1'b0;
    logic          cmd_valid, pix_valid, sleep_out, disp_on, err_abort;
    logic [7:0]    cmd_code, madctl, colmod;
    logic [CW-1:0] pix_x, pix_y;
    logic [15:0]   pix_data;

    always #5 clk = ~clk;

    lcd_spi_sink #(.SYNC_STAGES(2), .COORD_W(CW)) dut (
        .clk(clk), .resetn(resetn), .lcd_resetn(lcd_resetn),
        .lcd_clk(lcd_clk), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .sleep_out(sleep_out), .disp_on(disp_on), .madctl(madctl), .colmod(colmod),
        .err_abort(err_abort)
    );

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [15:0]   d;
    } pix_t;

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic [7:0] e_code;
        logic       e_sleep;
        logic       e_disp;
        logic [7:0] e_mad;
        logic [7:0] e_col;
        logic [7:0] e_ncmd;
    } vec_t;

    pix_t       got_q[$], exp_q[$];
    logic [7:0] cmd_q[$];
    int         abort_n = 0;
    int         n_tests = 0, n_fail = 0;

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (pix_valid) got_q.push_back({pix_x, pix_y, pix_data});
        if (cmd_valid) cmd_q.push_back(cmd_code);
        if (err_abort) abort_n++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic pix_t got_pix(input int i);
        return (got_q.size() > i) ? got_q[i] : '1;
    endfunction

    function automatic pix_t mkpix(input int px, input int py, input logic [15:0] d);
        return {CW'(px), CW'(py), d};
    endfunction

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        cmd_q.delete();
        abort_n = 0;
    endtask

    // Send the top n bits of b, CS framed per byte like the driver does
    task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
        lcd_cs = 1'b0;
        lcd_rs = dc;
        repeat (4) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            lcd_data = b[3'(7 - i)];
            repeat (4) @(posedge clk);
            lcd_clk = 1'b1;
            repeat (4) @(posedge clk);
            lcd_clk = 1'b0;
        end
        repeat (4) @(posedge clk);
        lcd_cs = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    task automatic send4(input logic [7:0] c, input logic [31:0] w);
        send(1'b0, c);
        for (int i = 3; i >= 0; i--) send(1'b1, w[8*i +: 8]);
    endtask

    task automatic panel_reset();
        lcd_resetn = 1'b0;
        repeat (8) @(posedge clk);
        lcd_resetn = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_cmd, m_mad, m_col;
    logic [7:0] m_par[$];
    int         m_xs, m_xe, m_ys, m_ye, m_ncmd;
    logic       m_sleep, m_disp;

    task automatic model_init();
        m_cmd = 8'h00; m_mad = 8'h00; m_col = 8'h00; m_par.delete();
        m_xs = 0; m_ys = 0; m_xe = SPAN - 1; m_ye = SPAN - 1;
        m_sleep = 1'b0; m_disp = 1'b0; m_ncmd = 0;
    endtask

    // Pixel k of a RAMWR lands at raster position k of the (possibly wrapping) window
    task automatic model_byte(input logic dc, input logic [7:0] b);
        int n, k, w, h;
        if (!dc) begin
            m_cmd = b;
            m_par.delete();
            m_ncmd++;
            if (b == 8'h11) m_sleep = 1'b1;
            if (b == 8'h10) m_sleep = 1'b0;
            if (b == 8'h29) m_disp = 1'b1;
            if (b == 8'h28) m_disp = 1'b0;
        end else begin
            m_par.push_back(b);
            n = m_par.size();
            if (m_cmd == 8'h2A && n == 4) begin
                m_xs = {m_par[0], m_par[1]} % SPAN;
                m_xe = {m_par[2], m_par[3]} % SPAN;
            end else if (m_cmd == 8'h2B && n == 4) begin
                m_ys = {m_par[0], m_par[1]} % SPAN;
                m_ye = {m_par[2], m_par[3]} % SPAN;
            end else if (m_cmd == 8'h36 && n == 1) begin
                m_mad = b;
            end else if (m_cmd == 8'h3A && n == 1) begin
                m_col = b;
            end else if (m_cmd == 8'h2C && n % 2 == 0) begin
                k = n / 2 - 1;
                w = (m_xe - m_xs + SPAN) % SPAN + 1;
                h = (m_ye - m_ys + SPAN) % SPAN + 1;
                exp_q.push_back(mkpix((m_xs + k % w) % SPAN, (m_ys + (k / w) % h) % SPAN,
                                      {m_par[n-2], m_par[n-1]}));
            end
        end
    endtask

    task automatic send_m(input logic dc, input logic [7:0] b);
        send(dc, b);
        model_byte(dc, b);
    endtask

    function automatic logic [31:0] rnd_window();
        int s, e;
        s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(SPAN - 4, SPAN - 1))
                                        : int'($urandom_range(0, 20));
        e = (s + int'($urandom_range(0, 3))) % SPAN;
        // Junk above the counter width must be truncated away
        s = s + int'($urandom_range(0, 127)) * SPAN;
        return {16'(s), 16'(e)};
    endfunction

    vec_t vt[11];
    pix_t exp3[5];
    pix_t exp8[5];

    initial begin
        logic [7:0] rc;
        logic [31:0] wb;
        int nb, op;
        logic [7:0] cmds[11];

        vt[0]  = '{1'b0, 8'h11, 8'h11, 1'b1, 1'b0, 8'h00, 8'h00, 8'd1};
        vt[1]  = '{1'b0, 8'h29, 8'h29, 1'b1, 1'b1, 8'h00, 8'h00, 8'd2};
        vt[2]  = '{1'b0, 8'h3A, 8'h3A, 1'b1, 1'b1, 8'h00, 8'h00, 8'd3};
        vt[3]  = '{1'b1, 8'h05, 8'h3A, 1'b1, 1'b1, 8'h00, 8'h05, 8'd3};
        vt[4]  = '{1'b1, 8'h55, 8'h3A, 1'b1, 1'b1, 8'h00, 8'h05, 8'd3};
        vt[5]  = '{1'b0, 8'h36, 8'h36, 1'b1, 1'b1, 8'h00, 8'h05, 8'd4};
        vt[6]  = '{1'b1, 8'hA0, 8'h36, 1'b1, 1'b1, 8'hA0, 8'h05, 8'd4};
        vt[7]  = '{1'b0, 8'h28, 8'h28, 1'b1, 1'b0, 8'hA0, 8'h05, 8'd5};
        vt[8]  = '{1'b0, 8'h10, 8'h10, 1'b0, 1'b0, 8'hA0, 8'h05, 8'd6};
        vt[9]  = '{1'b1, 8'h77, 8'h10, 1'b0, 1'b0, 8'hA0, 8'h05, 8'd6};
        vt[10] = '{1'b0, 8'h29, 8'h29, 1'b0, 1'b1, 8'hA0, 8'h05, 8'd7};
        exp3[0] = mkpix(0, 0, 16'h1000); exp3[1] = mkpix(1, 0, 16'h1001);
        exp3[2] = mkpix(0, 1, 16'h1002); exp3[3] = mkpix(1, 1, 16'h1003);
        exp3[4] = mkpix(0, 0, 16'h1004);
        exp8[0] = mkpix(510, 5, 16'h2000); exp8[1] = mkpix(511, 5, 16'h2001);
        exp8[2] = mkpix(0, 5, 16'h2002);   exp8[3] = mkpix(1, 5, 16'h2003);
        exp8[4] = mkpix(510, 5, 16'h2004);
        cmds = '{8'h2A, 8'h2B, 8'h2C, 8'h36, 8'h3A, 8'h11, 8'h10, 8'h29, 8'h28, 8'h00, 8'hB2};

        repeat (5) @(posedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        check("reset_outputs",
              64'({cmd_valid, cmd_code, pix_valid, pix_x, pix_y, pix_data,
                   sleep_out, disp_on, madctl, colmod, err_abort}), 64'd0);

        // Flag / parameter command table
        clear_mon();
        for (int i = 0; i < 11; i++) begin
            send(vt[i].dc, vt[i].b);
            check($sformatf("vec%0d", i),
                  64'({cmd_code, sleep_out, disp_on, madctl, colmod,
                       8'(cmd_q.size()), 8'(got_q.size())}),
                  64'({vt[i].e_code, vt[i].e_sleep, vt[i].e_disp, vt[i].e_mad,
                       vt[i].e_col, vt[i].e_ncmd, 8'd0}));
        end
        check("first_cmds", 64'({cmd_q[0], cmd_q[1]}), 64'({8'h11, 8'h29}));

        // Single addressed pixel
        clear_mon();
        send4(8'h2A, 32'h0028_0117);
        send4(8'h2B, 32'h0035_00BB);
        send(1'b0, 8'h2C); send(1'b1, 8'hF8); send(1'b1, 8'h00);
        check("single_pix_cnt", 64'(got_q.size()), 64'd1);
        check("single_pix", 64'(got_pix(0)), 64'(mkpix(40, 53, 16'hF800)));

        // 2x2 window wrap
        clear_mon();
        send4(8'h2A, 32'h0000_0001);
        send4(8'h2B, 32'h0000_0001);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'h10); send(1'b1, 8'(i));
        end
        check("wrap_cnt", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("wrap_pix%0d", i), 64'(got_pix(i)), 64'(exp3[i]));

        // Aborted partial byte between hi and lo
        clear_mon();
        send(1'b0, 8'h2C);
        send(1'b1, 8'hF8);
        send_bits(1'b1, 8'hAA, 5);
        check("abort_no_pix", 64'(got_q.size()), 64'd0);
        send(1'b1, 8'h1F);
        check("abort_cnt", 64'(abort_n), 64'd1);
        check("abort_pix_cnt", 64'(got_q.size()), 64'd1);
        check("abort_pix", 64'(got_pix(0)), 64'(mkpix(0, 0, 16'hF81F)));

        // Window with xs > xe wraps through the counter range; extra CASET byte ignored
        clear_mon();
        send4(8'h2A, 32'h01FE_0001);
        send(1'b1, 8'h33);
        send4(8'h2B, 32'h0005_0005);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'h20); send(1'b1, 8'(i));
        end
        check("xwrap_cnt", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("xwrap_pix%0d", i), 64'(got_pix(i)), 64'(exp8[i]));

        // Lone hi byte followed by a command is discarded
        clear_mon();
        send(1'b0, 8'h2C); send(1'b1, 8'hAA); send(1'b0, 8'h00); send(1'b1, 8'hBB);
        check("lone_hi", 64'(got_q.size()), 64'd0);

        // Panel reset in the middle of a RAMWR
        clear_mon();
        send(1'b0, 8'h2C); send(1'b1, 8'hAB);
        lcd_resetn = 1'b0;
        repeat (6) @(posedge clk);
        check("panel_rst_outputs",
              64'({cmd_valid, cmd_code, pix_valid, pix_x, pix_y, pix_data,
                   sleep_out, disp_on, madctl, colmod, err_abort}), 64'd0);
        lcd_resetn = 1'b1;
        repeat (8) @(posedge clk);
        send(1'b0, 8'h2C); send(1'b1, 8'h00); send(1'b1, 8'h1F);
        send(1'b1, 8'h12); send(1'b1, 8'h34);
        check("post_rst_cnt", 64'(got_q.size()), 64'd2);
        check("post_rst_pix0", 64'(got_pix(0)), 64'(mkpix(0, 0, 16'h001F)));
        check("post_rst_pix1", 64'(got_pix(1)), 64'(mkpix(1, 0, 16'h1234)));

        // Randomized DCS stream against the reference model
        panel_reset();
        clear_mon();
        model_init();
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 10));
            rc = cmds[op];
            send_m(1'b0, rc);
            if (rc == 8'h2A || rc == 8'h2B) begin
                wb = rnd_window();
                nb = int'($urandom_range(3, 5));
                for (int j = 0; j < nb; j++)
                    send_m(1'b1, (j < 4) ? wb[8*(3-j) +: 8] : 8'($urandom));
            end else begin
                nb = (rc == 8'h2C) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 2));
                for (int j = 0; j < nb; j++) send_m(1'b1, 8'($urandom));
            end
        end
        check("rand_pix_cnt", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_pix%0d", i), 64'(got_pix(i)), 64'(exp_q[i]));
        check("rand_cmd_cnt", 64'(cmd_q.size()), 64'(m_ncmd));
        check("rand_flags",
              64'({cmd_code, sleep_out, disp_on, madctl, colmod, 8'(abort_n)}),
              64'({m_cmd, m_sleep, m_disp, m_mad, m_col, 8'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
